move_deserializer: RTL and testbench

Receive side of the four-word move stream: it accepts up to four 32-bit move words per cycle from the move-generation pipeline. It drops zero (empty) words and packs the non-zero words, in arrival order, into one wide move-list register. It counts the packed moves and flags completion, so the move list can be handed back as a single parallel vector to the search logic. It is the inverse of the block that streams a packed move list out four words per cycle.

---
 rtl/move_deserializer.sv | 122 ++++++++++++
 tb/tb_move_deserializer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/move_deserializer.sv
// rtl/move_deserializer.sv - packs non-zero move words from a four-lane beat stream into a parallel move list
//
// Accepts beats of four 32-bit move words (in1 oldest), drops zero words,
// packs the rest in arrival order into a wide move-list register, counts
// them and raises done once the final beat (in_last or beat limit) lands.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   start             clears the list and begins a new collection
//   in1..in4          move words of one beat, 0 = empty lane
//   in_valid, in_last beat present / final beat of the stream
//   ready             block accepts a beat this cycle (COLLECT)
//   out               packed list, slot i at [32*MAX_MOVES-1-32*i -: 32]
//   move_count_out    number of packed moves, valid while done
//   done              collection complete, outputs stable until start
module move_deserializer #(
    parameter int MAX_MOVES = 756,
    parameter int CNT_W     = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [31:0]               in1,
    input  logic [31:0]               in2,
    input  logic [31:0]               in3,
    input  logic [31:0]               in4,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      ready,
    output logic [32*MAX_MOVES-1:0]   out,
    output logic [31:0]               move_count_out,
    output logic                      done
);

    localparam int BEATS = MAX_MOVES / 4;
    localparam int OUT_W = 32 * MAX_MOVES;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   ptr_q;
    logic [CNT_W-1:0]   beat_q;
    logic [OUT_W-1:0]   out_q;
    logic [31:0]        count_q;
    logic               ready_q;
    logic               done_q;

    logic [31:0]        lanes    [4];
    logic [3:0]         nz;
    int                 slot_idx [4];
    logic [2:0]         nz_cnt;
    logic [CNT_W-1:0]   ptr_d;
    logic [CNT_W-1:0]   beat_d;
    logic               accept;
    logic               last_beat;

    // Each non-zero lane lands at ptr plus the number of non-zero lanes
    // ahead of it in the same beat, which compacts the beat in order.
    always_comb begin
        lanes[0] = in1;
        lanes[1] = in2;
        lanes[2] = in3;
        lanes[3] = in4;
        nz_cnt   = 3'd0;
        for (int k = 0; k < 4; k++) begin
            nz[k]       = (lanes[k] != 32'd0);
            slot_idx[k] = int'(ptr_q) + int'(nz_cnt);
            nz_cnt      = nz_cnt + {2'b00, nz[k]};
        end
        ptr_d     = ptr_q + CNT_W'(nz_cnt);
        beat_d    = beat_q + CNT_W'(1);
        accept    = (state_q == S_COLLECT) && in_valid && !start;
        last_beat = in_last || (beat_d == CNT_W'(BEATS));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            beat_q  <= '0;
            out_q   <= '0;
            count_q <= '0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (start) begin
            // start wins over any beat presented in the same cycle
            state_q <= S_COLLECT;
            ptr_q   <= '0;
            beat_q  <= '0;
            out_q   <= '0;
            count_q <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else if (accept) begin
            // slot_idx stays below MAX_MOVES: at most 4 moves per beat
            // and at most BEATS beats are ever accepted.
            for (int k = 0; k < 4; k++) begin
                if (nz[k]) begin
                    out_q[OUT_W-1-32*slot_idx[k] -: 32] <= lanes[k];
                end
            end
            ptr_q  <= ptr_d;
            beat_q <= beat_d;
            if (last_beat) begin
                state_q <= S_DONE;
                ready_q <= 1'b0;
                done_q  <= 1'b1;
                count_q <= 32'(ptr_d);
            end
        end
    end

    assign ready          = ready_q;
    assign done           = done_q;
    assign out            = out_q;
    assign move_count_out = count_q;

endmodule

// File: tb/tb_move_deserializer.sv
// tb/tb_move_deserializer.sv - scoreboard bench for move_deserializer
module tb_move_deserializer;

    localparam int MAX_MOVES = 756;
    localparam int CNT_W     = 10;
    localparam int BEATS     = MAX_MOVES / 4;
    localparam int OUT_W     = 32 * MAX_MOVES;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [31:0]        in1 = '0, in2 = '0, in3 = '0, in4 = '0;
    logic               in_valid = 1'b0;
    logic               in_last = 1'b0;
    logic               ready;
    logic [OUT_W-1:0]   out;
    logic [31:0]        move_count_out;
    logic               done;

    move_deserializer #(.MAX_MOVES(MAX_MOVES), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in1(in1), .in2(in2), .in3(in3), .in4(in4),
        .in_valid(in_valid), .in_last(in_last),
        .ready(ready), .out(out), .move_count_out(move_count_out), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned      cnt;
        logic [OUT_W-1:0] vec;
    } exp_t;

    exp_t              exp_q[$];
    int unsigned       m_list[$];
    int                m_beats;
    bit                m_collect;
    logic [OUT_W-1:0]  last_vec;
    int unsigned       last_cnt;
    int                errors = 0;
    int                checks = 0;

    function automatic logic [OUT_W-1:0] build_vec(input int unsigned l[$]);
        logic [OUT_W-1:0] v;
        v = '0;
        for (int i = 0; i < l.size(); i++) v[OUT_W-1-32*i -: 32] = l[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            for (int i = 0; i < MAX_MOVES; i++) begin
                if (act[OUT_W-1-32*i -: 32] !== exp[OUT_W-1-32*i -: 32]) begin
                    $display("FAIL %s: slot %0d got 0x%0h expected 0x%0h", name, i,
                             act[OUT_W-1-32*i -: 32], exp[OUT_W-1-32*i -: 32]);
                    break;
                end
            end
        end
    endtask

    // Monitor: each rising done must match the oldest expected completion.
    bit done_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            done_prev = 1'b0;
        end else begin
            if (done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no completion");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("move_count", move_count_out, e.cnt);
                    chk_vec("move_list", out, e.vec);
                end
            end
            done_prev = done;
        end
    end

    // Called right after a negedge; leaves the bench right after a negedge.
    task automatic start_pulse(input bit collide, input logic [31:0] w1);
        start    = 1'b1;
        in_valid = collide;
        in1      = w1;
        in2      = '0; in3 = '0; in4 = '0;
        in_last  = 1'b0;
        m_list.delete();
        m_beats   = 0;
        m_collect = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        chk("ready_after_start", {31'd0, ready}, 32'd1);
        chk("done_after_start", {31'd0, done}, 32'd0);
    endtask

    task automatic send_beat(input logic [31:0] a, b, c, d, input bit last, input int stall_max);
        bit fin;
        logic [31:0] w[4];
        repeat ($urandom_range(0, stall_max)) begin
            in_valid = 1'b0;
            in1 = $urandom; in2 = $urandom; in3 = $urandom; in4 = $urandom;
            in_last = $urandom_range(0, 1);
            @(negedge clk);
        end
        w[0] = a; w[1] = b; w[2] = c; w[3] = d;
        in1 = a; in2 = b; in3 = c; in4 = d;
        in_valid = 1'b1;
        in_last  = last;
        fin = 1'b0;
        if (m_collect) begin
            foreach (w[k]) if (w[k] != 0) m_list.push_back(w[k]);
            m_beats++;
            if (last || m_beats == BEATS) begin
                exp_t e;
                e.cnt = m_list.size();
                e.vec = build_vec(m_list);
                exp_q.push_back(e);
                last_vec  = e.vec;
                last_cnt  = e.cnt;
                m_collect = 1'b0;
                fin       = 1'b1;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (fin) begin
            chk("done_timing", {31'd0, done}, 32'd1);
            chk("ready_in_done", {31'd0, ready}, 32'd0);
        end
    endtask

    initial begin
        m_collect = 1'b0;
        m_beats   = 0;
        last_vec  = '0;
        last_cnt  = 0;

        // reset values
        repeat (3) @(negedge clk);
        chk_vec("reset_out", out, '0);
        chk("reset_count", move_count_out, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_ready", {31'd0, ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_ready", {31'd0, ready}, 32'd0);

        // compaction across lanes
        start_pulse(1'b0, 32'd0);
        send_beat(32'd0, 32'h11, 32'd0, 32'h22, 1'b1, 0);

        // DONE ignores beats and holds its outputs
        send_beat(32'h33, 32'h44, 32'h55, 32'h66, 1'b1, 0);
        send_beat(32'h77, 32'd0, 32'd0, 32'd0, 1'b0, 0);
        chk_vec("done_hold_out", out, last_vec);
        chk("done_hold_count", move_count_out, last_cnt);
        chk("done_hold_done", {31'd0, done}, 32'd1);

        // full-length stream with random stalls, ends on beat limit
        start_pulse(1'b0, 32'd0);
        for (int b = 0; b < BEATS; b++)
            send_beat(4*b+1, 4*b+2, 4*b+3, 4*b+4, 1'b0, 2);

        // sparse stream with early last
        start_pulse(1'b0, 32'd0);
        for (int b = 0; b < 5; b++)
            send_beat(32'd0, 32'd0, 32'(5 + b), 32'd0, b == 4, 1);

        // random collections, random empty lanes
        for (int n = 0; n < 6; n++) begin
            int len;
            len = $urandom_range(1, 25);
            start_pulse(1'b0, 32'd0);
            for (int b = 0; b < len; b++) begin
                logic [31:0] r[4];
                foreach (r[k]) r[k] = ($urandom_range(0, 1) != 0) ? $urandom : 32'd0;
                send_beat(r[0], r[1], r[2], r[3], b == len - 1, 2);
            end
        end

        // start collides with a beat while in DONE
        start_pulse(1'b1, 32'hAA);
        chk_vec("collision_cleared", out, '0);
        chk("collision_count", move_count_out, 32'd0);
        send_beat(32'hBB, 32'd0, 32'd0, 32'd0, 1'b1, 0);

        // reset mid-collection
        start_pulse(1'b0, 32'd0);
        for (int b = 0; b < 50; b++)
            send_beat($urandom | 32'd1, $urandom, 32'd0, $urandom | 32'd1, 1'b0, 1);
        #2 rst_n = 1'b0;
        m_collect = 1'b0;
        m_list.delete();
        #1;
        chk_vec("midreset_out", out, '0);
        chk("midreset_count", move_count_out, 32'd0);
        chk("midreset_done", {31'd0, done}, 32'd0);
        chk("midreset_ready", {31'd0, ready}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_beat(32'h1, 32'h2, 32'h3, 32'h4, 1'b0, 0);
        send_beat(32'h5, 32'h6, 32'h7, 32'h8, 1'b1, 0);
        chk_vec("idle_ignore_out", out, '0);
        chk("idle_ignore_done", {31'd0, done}, 32'd0);
        chk("idle_ignore_ready", {31'd0, ready}, 32'd0);

        // recovery after reset
        start_pulse(1'b0, 32'd0);
        send_beat(32'h9, 32'd0, 32'hA, 32'd0, 1'b0, 1);
        send_beat(32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1);

        repeat (3) @(negedge clk);
        chk("pending_completions", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
